// File: rtl/id_scan_pkg.sv
// Shared types and constants for the token scanner.
// Character ranges, record kinds and FSM states.
package id_scan_pkg;

  localparam logic [7:0] DIGIT_LO = 8'd48;
  localparam logic [7:0] DIGIT_HI = 8'd57;
  localparam logic [7:0] UPPER_LO = 8'd65;
  localparam logic [7:0] UPPER_HI = 8'd90;
  localparam logic [7:0] LOWER_LO = 8'd97;
  localparam logic [7:0] LOWER_HI = 8'd122;

  localparam logic [1:0] KIND_NONE   = 2'd0;
  localparam logic [1:0] KIND_IDENT  = 2'd1;
  localparam logic [1:0] KIND_NUMBER = 2'd2;
  localparam logic [1:0] KIND_BAD    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_T_ID  = 2'd1,
    S_T_NUM = 2'd2,
    S_T_BAD = 2'd3
  } state_e;

  // Record kind reported when a token closes in a given state.
  function automatic logic [1:0] kind_of(input state_e s);
    logic [1:0] k;
    k = KIND_NONE;
    unique case (s)
      S_IDLE:  k = KIND_NONE;
      S_T_ID:  k = KIND_IDENT;
      S_T_NUM: k = KIND_NUMBER;
      S_T_BAD: k = KIND_BAD;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/char_class.sv
// Combinational ASCII character classifier.
// Anything not a digit or letter is a separator.
module char_class
  import id_scan_pkg::*;
(
  input  logic [7:0] char_i,
  output logic       is_digit_o,
  output logic       is_alpha_o
);

  logic upper;
  logic lower;

  assign upper = (char_i >= UPPER_LO) && (char_i <= UPPER_HI);
  assign lower = (char_i >= LOWER_LO) && (char_i <= LOWER_HI);

  assign is_digit_o = (char_i >= DIGIT_LO) && (char_i <= DIGIT_HI);
  assign is_alpha_o = upper || lower;

endmodule

// File: rtl/id_token_scanner.sv
// Frames an ASCII stream into tokens and emits one
// classified record at a time over valid/ready.
module id_token_scanner
  import id_scan_pkg::*;
#(
  parameter int LEN_W = 6,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_char,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  output logic [1:0]       out_kind,
  output logic [LEN_W-1:0] out_len,
  input  logic             out_ready,
  output logic [CNT_W-1:0] id_count
);

  logic is_digit;
  logic is_alpha;
  logic alnum;
  logic acc;
  logic hs;
  logic close;

  state_e           state_q, state_d;
  state_e           tok_st;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] len_inc;
  logic [LEN_W-1:0] tok_len;
  logic             ov_q, ov_d;
  logic [1:0]       kind_q, kind_d;
  logic [LEN_W-1:0] olen_q, olen_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  char_class u_cc (
    .char_i     (in_char),
    .is_digit_o (is_digit),
    .is_alpha_o (is_alpha)
  );

  assign alnum = is_digit || is_alpha;
  assign acc   = in_valid && !ov_q;
  assign hs    = ov_q && out_ready;

  assign len_inc = (&len_q) ? len_q : len_q + 1'b1;

  // Token state after including the current character.
  always_comb begin
    tok_st  = state_q;
    tok_len = len_q;
    unique case (state_q)
      S_IDLE: begin
        if (is_alpha) begin
          tok_st  = S_T_ID;
          tok_len = LEN_W'(1);
        end else if (is_digit) begin
          tok_st  = S_T_NUM;
          tok_len = LEN_W'(1);
        end
      end
      S_T_ID: begin
        if (alnum) tok_len = len_inc;
      end
      S_T_NUM: begin
        if (is_digit) begin
          tok_len = len_inc;
        end else if (is_alpha) begin
          tok_st  = S_T_BAD;
          tok_len = len_inc;
        end
      end
      S_T_BAD: begin
        if (alnum) tok_len = len_inc;
      end
    endcase
  end

  // A separator closes an open token; in_last closes
  // a token that includes the last character.
  assign close = ((state_q != S_IDLE) && !alnum)
              || (alnum && in_last);

  // Next-state: FSM, length, record and counter.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    ov_d    = ov_q;
    kind_d  = kind_q;
    olen_d  = olen_q;
    cnt_d   = cnt_q;
    if (hs) begin
      ov_d = 1'b0;
      if ((kind_q == KIND_IDENT) && !(&cnt_q))
        cnt_d = cnt_q + 1'b1;
    end
    if (acc) begin
      if (close) begin
        ov_d    = 1'b1;
        kind_d  = kind_of(tok_st);
        olen_d  = tok_len;
        state_d = S_IDLE;
        len_d   = '0;
      end else begin
        state_d = tok_st;
        len_d   = tok_len;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      ov_q    <= 1'b0;
      kind_q  <= KIND_NONE;
      olen_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      ov_q    <= ov_d;
      kind_q  <= kind_d;
      olen_q  <= olen_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = !ov_q;
  assign out_valid = ov_q;
  assign out_kind  = kind_q;
  assign out_len   = olen_q;
  assign id_count  = cnt_q;

endmodule
